// File: rtl/sensor_crossbar_n.sv
// sensor_crossbar_n: decodes a UART command byte, triggers the addressed sensor channel and
// streams its word back MSB byte first. Define SENSOR_XBAR_CHKSUM_EN for a trailing XOR byte.
module sensor_crossbar_n #(
  parameter int                N_CH        = 2,
  parameter int                DATA_W      = 16,
  parameter logic [N_CH*8-1:0] CMD_CODES   = {8'h44, 8'h54},
  parameter int                TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0]        ERR_BYTE    = 8'hEE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             uart_rx,
  input  logic                   uart_rx_valid,
  output logic [7:0]             uart_tx,
  output logic                   uart_tx_valid,
  input  logic                   uart_ready,
  output logic [N_CH-1:0]        sens_start,
  input  logic [N_CH*DATA_W-1:0] sens_data,
  input  logic [N_CH-1:0]        sens_avail,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);

  localparam int NB    = DATA_W / 8;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam int IDX_W = $clog2(NB + 1);
`ifdef SENSOR_XBAR_CHKSUM_EN
  localparam int LAST_IDX = NB;
`else
  localparam int LAST_IDX = NB - 1;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_SEND, S_ERR} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CH_W-1:0]   r_ch;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_drop;
  logic              w_hit;
  logic [CH_W-1:0]   w_hit_ch;
  logic              w_avail;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_accept;
  logic              w_timeout;
  logic              w_last;
  logic [7:0]        w_send_byte;

`ifdef SENSOR_XBAR_CHKSUM_EN
  logic [7:0] r_chk;

  function automatic logic [7:0] f_xor_bytes(input logic [DATA_W-1:0] d);
    logic [7:0] acc;
    acc = '0;
    for (int b = 0; b < NB; b++) acc ^= d[8*b +: 8];
    return acc;
  endfunction

  assign w_send_byte = (r_idx == IDX_W'(NB)) ? r_chk : r_shift[DATA_W-1 -: 8];
`else
  assign w_send_byte = r_shift[DATA_W-1 -: 8];
`endif

  // Iterate downwards so the lowest matching channel index has the final say.
  always_comb begin
    w_hit    = 1'b0;
    w_hit_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (uart_rx == CMD_CODES[8*i +: 8]) begin
        w_hit    = 1'b1;
        w_hit_ch = CH_W'(i);
      end
    end
  end

  assign w_avail    = sens_avail[r_ch];
  assign w_sel_data = sens_data[DATA_W*r_ch +: DATA_W];
  assign w_accept   = uart_ready && (r_state == S_SEND || r_state == S_ERR);
  assign w_timeout  = (r_cnt == CNT_LAST);
  assign w_last     = (r_idx == IDX_W'(LAST_IDX));
  assign busy       = (r_state != S_IDLE);
  assign drop_cnt   = r_drop;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Data wins over timeout when both occur in the same WAIT cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (uart_rx_valid && w_hit) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (w_avail) w_next = S_SEND;
               else if (w_timeout) w_next = S_ERR;
      S_SEND:  if (w_accept && w_last) w_next = S_IDLE;
      S_ERR:   if (w_accept) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sens_start    = '0;
    uart_tx_valid = 1'b0;
    uart_tx       = '0;
    case (r_state)
      S_START: sens_start[r_ch] = 1'b1;
      S_SEND: begin
        uart_tx_valid = 1'b1;
        uart_tx       = w_send_byte;
      end
      S_ERR: begin
        uart_tx_valid = 1'b1;
        uart_tx       = ERR_BYTE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ch    <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_drop  <= '0;
`ifdef SENSOR_XBAR_CHKSUM_EN
      r_chk   <= '0;
`endif
    end else begin
      if (uart_rx_valid && (r_state != S_IDLE || !w_hit) && r_drop != 8'hFF)
        r_drop <= r_drop + 8'd1;
      case (r_state)
        S_IDLE:  if (uart_rx_valid && w_hit) r_ch <= w_hit_ch;
        S_START: r_cnt <= '0;
        S_WAIT: begin
          if (w_avail) begin
            r_shift <= w_sel_data;
            r_idx   <= '0;
`ifdef SENSOR_XBAR_CHKSUM_EN
            r_chk   <= f_xor_bytes(w_sel_data);
`endif
          end else if (!w_timeout) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SEND: begin
          if (w_accept) begin
            r_idx   <= r_idx + IDX_W'(1);
            r_shift <= r_shift << 8;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
